// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic types used by ALU-side blocks
package arith_pkg;

  typedef enum logic {
    Unsigned = 1'b0,
    Signed   = 1'b1
  } Arith_SignedUnsigned_T;

endpackage

// File: rtl/util_pkg.sv
// rtl/util_pkg.sv - shared clock/reset control bundle
package util_pkg;

  typedef struct packed {
    logic clock;
    logic reset;
  } Util_Control_T;

endpackage

// File: rtl/arith_extend_lane.sv
// rtl/arith_extend_lane.sv - single combinational lane: sign/zero extend, pass-through or truncate
module arith_extend_lane
  import arith_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]       in,
  input  Arith_SignedUnsigned_T sign,
  output logic [OUT_W-1:0]      out
);

  if (OUT_W > IN_W) begin : g_widen
    logic fill;
    assign fill = (sign == Signed) & in[IN_W-1];
    assign out  = {{(OUT_W-IN_W){fill}}, in};
  end else if (OUT_W == IN_W) begin : g_same
    logic unused_sign;
    assign unused_sign = sign;
    assign out = in;
  end else begin : g_trunc
    // Upper input bits and the mode are irrelevant when narrowing.
    logic unused_bits;
    assign unused_bits = ^{sign, in[IN_W-1:OUT_W]};
    assign out = in[OUT_W-1:0];
  end

endmodule

// File: rtl/arith_extend.sv
// rtl/arith_extend.sv - DEPTH-lane width extender; output register bank under ARITH_EXTEND_REG_EN
module arith_extend
  import arith_pkg::*;
  import util_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 1
) (
  input  Util_Control_T         ctrl,
  input  logic [IN_W-1:0]       in  [DEPTH],
  output logic [OUT_W-1:0]      out [DEPTH],
  input  Arith_SignedUnsigned_T sign
);

  logic [OUT_W-1:0] ext [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_lane
    arith_extend_lane #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .in   (in[i]),
      .sign (sign),
      .out  (ext[i])
    );
  end

`ifdef ARITH_EXTEND_REG_EN
  always_ff @(posedge ctrl.clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      out[i] <= ctrl.reset ? '0 : ext[i];
    end
  end
`else
  // Combinational build: clock and reset have no role.
  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl.clock, ctrl.reset};
  assign out = ext;
`endif

endmodule

// File: tb/tb_arith_extend.sv
// tb/tb_arith_extend.sv - directed self-checking bench for arith_extend (both ARITH_EXTEND_REG_EN builds)
module tb_arith_extend;
  import arith_pkg::*;
  import util_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  Util_Control_T ctrl;
  assign ctrl.clock = clk;
  assign ctrl.reset = rst;
  always #5 clk = ~clk;

  Arith_SignedUnsigned_T sign = Signed;

  logic [3:0] in_a  [2];
  logic [7:0] out_a [2];
  logic [7:0] in_e  [1];
  logic [7:0] out_e [1];
  logic [7:0] in_t  [1];
  logic [3:0] out_t [1];

  arith_extend #(.IN_W(4), .OUT_W(8), .DEPTH(2)) u_dut (
    .ctrl(ctrl), .in(in_a), .out(out_a), .sign(sign));
  arith_extend #(.IN_W(8), .OUT_W(8), .DEPTH(1)) u_dut_eq (
    .ctrl(ctrl), .in(in_e), .out(out_e), .sign(sign));
  arith_extend #(.IN_W(8), .OUT_W(4), .DEPTH(1)) u_dut_tr (
    .ctrl(ctrl), .in(in_t), .out(out_t), .sign(sign));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a0, input logic [3:0] a1, input Arith_SignedUnsigned_T s,
                       input logic r);
    in_a[0] = a0;
    in_a[1] = a1;
    sign    = s;
    rst     = r;
  endtask

  // Registered build: advance one edge and sample 1 time unit later.
  // Combinational build: just let the inputs settle.
  task automatic step();
`ifdef ARITH_EXTEND_REG_EN
    @(posedge clk);
`endif
    #1;
  endtask

  initial begin
    in_e[0] = 8'h00;
    in_t[0] = 8'h00;
    drive(4'h0, 4'h0, Signed, 1'b1);
    @(negedge clk);

`ifdef ARITH_EXTEND_REG_EN
    step();
    check("reset_lane0", out_a[0], 8'h00);
    check("reset_lane1", out_a[1], 8'h00);

    @(negedge clk);
    drive(4'ha, 4'h5, Signed, 1'b1);
    in_e[0] = 8'h80;
    in_t[0] = 8'hc3;
    step();
    check("reset_ignores_in0", out_a[0], 8'h00);
    check("reset_ignores_in1", out_a[1], 8'h00);
    check("reset_ignores_eq", out_e[0], 8'h00);
    check("reset_ignores_tr", out_t[0], 4'h0);

    @(negedge clk);
    drive(4'ha, 4'h5, Signed, 1'b0);
    check("first_result_not_early", out_a[0], 8'h00);
`else
    drive(4'h8, 4'h0, Signed, 1'b1);
    step();
    check("comb_signed_no_clock", out_a[0], 8'hf8);
    check("comb_reset_no_effect", out_a[1], 8'h00);
    drive(4'ha, 4'h5, Signed, 1'b0);
    in_e[0] = 8'h80;
    in_t[0] = 8'hc3;
`endif
    step();
    check("signed_lane0", out_a[0], 8'hfa);
    check("signed_lane1", out_a[1], 8'h05);
    check("eq_width_signed", out_e[0], 8'h80);
    check("trunc_signed", out_t[0], 4'h3);

    @(negedge clk);
    drive(4'ha, 4'h5, Unsigned, 1'b0);
    step();
    check("unsigned_lane0", out_a[0], 8'h0a);
    check("unsigned_lane1", out_a[1], 8'h05);
    check("eq_width_unsigned", out_e[0], 8'h80);
    check("trunc_unsigned", out_t[0], 4'h3);

    @(negedge clk);
    drive(4'h0, 4'h0, Unsigned, 1'b0);
`ifdef ARITH_EXTEND_REG_EN
    #1;
    check("hold_one_cycle", out_a[0], 8'h0a);
`endif
    step();
    check("zero_lane0", out_a[0], 8'h00);
    check("zero_lane1", out_a[1], 8'h00);

    @(negedge clk);
    drive(4'h5, 4'hf, Signed, 1'b0);
    step();
    check("swap_lane0", out_a[0], 8'h05);
    check("swap_lane1", out_a[1], 8'hff);

    @(negedge clk);
    drive(4'h5, 4'hf, Unsigned, 1'b0);
    step();
    check("mode_change_lane1", out_a[1], 8'h0f);

    @(negedge clk);
    drive(4'h8, 4'h7, Signed, 1'b1);
    step();
`ifdef ARITH_EXTEND_REG_EN
    check("midstream_reset0", out_a[0], 8'h00);
    check("midstream_reset1", out_a[1], 8'h00);
`else
    check("comb_reset_lane0", out_a[0], 8'hf8);
    check("comb_reset_lane1", out_a[1], 8'h07);
`endif

    @(negedge clk);
    drive(4'h8, 4'h7, Signed, 1'b0);
    step();
    check("after_reset_lane0", out_a[0], 8'hf8);
    check("after_reset_lane1", out_a[1], 8'h07);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/arith_extend.md
# arith_extend

Parameterised multi-lane width extender for the arithmetic datapath. It widens each of DEPTH independent IN_W-bit operands to OUT_W bits, using either sign extension or zero extension as selected by a shared mode input. It sits between immediate/partial-word sources (instruction immediates, byte/halfword loads) and the ALU/writeback operand paths. The result is registered by default.

## Interface
Parameters:
- IN_W, default 16: input lane width in bits, ≥ 1
- OUT_W, default 32: output lane width in bits, ≥ 1
- DEPTH, default 1: number of independent lanes, ≥ 1

Ports:
- ctrl  input  Util_Control_T bundle: `clock` (single clock, rising edge) and `reset` (synchronous, active-high)
- in  input  IN_W × [DEPTH] unpacked array: operand per lane
- out  output  OUT_W × [DEPTH] unpacked array: extended result per lane
- sign  input  Arith_SignedUnsigned_T (1 bit): Signed = sign-extend, Unsigned = zero-extend; one setting shared by all lanes

## Operation
- Each lane i is independent: out[i] = ext(in[i]).
- OUT_W > IN_W, Signed: out[i] = {(OUT_W−IN_W){in[i][IN_W−1]}, in[i]}.
- OUT_W > IN_W, Unsigned: out[i] = {(OUT_W−IN_W){1'b0}, in[i]}.
- OUT_W == IN_W: out[i] = in[i], regardless of sign.
- OUT_W < IN_W: out[i] = in[i][OUT_W−1:0] (truncation), regardless of sign.
- X/Z on an unused `sign` value is not permitted; the encoding is Unsigned = 0, Signed = 1.
- There is no handshake and no valid signal: every lane is evaluated on every cycle.

## Timing
- Registered mode (macro defined, the default build): out[i] updates on the rising clock edge from the in/sign values sampled at that edge, giving 1-cycle latency.
- Reset: while `reset` is high at a clock edge, every out[i] is set to 0 and inputs are ignored. The first valid result appears on the first edge after `reset` deasserts.
- Reset asserted mid-stream: the next edge clears all lanes. Any in-flight value is discarded.
- `sign` change: it applies to the value captured at the same edge. There is no mixing between old and new mode.
- Combinational mode (macro undefined): out follows in/sign with zero latency. ctrl is unused, so reset has no effect on out.

## Configuration
- ARITH_EXTEND_REG_EN
  - Defined: output register stage present, with 1-cycle latency and synchronous reset to 0.
  - Undefined: purely combinational, with 0 latency, and `ctrl` is ignored.
- Extension results are identical in both modes.

## Structure
- Shared package (arith package, already used by ALU blocks) holds:
  - the Arith_SignedUnsigned_T enum (Unsigned = 1'b0, Signed = 1'b1) and its Signed/Unsigned constants
- Shared util package holds Util_Control_T, with `clock` and `reset` members.
- Sub-module: arith_extend_lane, a single combinational lane extender parameterised by IN_W/OUT_W that handles the >, ==, < width cases.
- The top level generates DEPTH lane instances, plus an optional output register bank under ARITH_EXTEND_REG_EN.

## Test plan
- Reset (IN_W=4, OUT_W=8, DEPTH=2, registered): hold reset for 1 edge with in={0,0} → out={8'h00,8'h00}; assert reset with nonzero in → out remains 0.
- Signed: in[0]=4'ha, in[1]=4'h5 → one edge later out[0]=8'hfa, out[1]=8'h05.
- Unsigned: same in → out[0]=8'h0a, out[1]=8'h05.
- Return to zero: in={0,0} after a nonzero pair → next edge out={8'h00,8'h00}. The previous value holds exactly 1 cycle.
- Width boundaries: with IN_W=OUT_W=8, Signed, in=8'h80 → out=8'h80. With IN_W=8, OUT_W=4, in=8'hc3 → out=4'h3.
- Combinational build (macro undefined): in[0]=4'h8, Signed → out[0]=8'hf8 in the same time step, with no clock edge required.
